// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  // WordOrByte encoding
  localparam logic WOB_WORD = 1'b1;
  localparam logic WOB_BYTE = 1'b0;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication/byte enables on the way
// out, load lane selection and sign extension on the way back.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic        st_word,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic        ld_word,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0] ld_byte;

  always_comb begin
    st_be    = BE_WORD;
    st_wdata = st_data;
    if (st_word == WOB_BYTE) begin
      st_be    = BE_BYTE0 << st_off;
      st_wdata = {4{st_data[7:0]}};
    end
  end

  assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];

  always_comb begin
    ld_data = {{24{ld_byte[7]}}, ld_byte};
    if (ld_word == WOB_WORD) begin
      ld_data = ld_rdata;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues one req/ack data-memory access per instruction
// and holds the upstream pipeline stalled until that access completes.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        WordOrByte,
  input  logic [31:0] ALUresult,
  input  logic [31:0] rs2,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        word_q, word_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ldata_q, ldata_d;
  logic        lvalid_q, lvalid_d;
  logic        err_q, err_d;

  logic        access;
  logic        misaligned;
  logic        stall_c;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  mem_lane_align u_align (
    .st_word  (WordOrByte),
    .st_off   (ALUresult[1:0]),
    .st_data  (rs2),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_word  (word_q),
    .ld_off   (off_q),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

  assign access     = MemRead | MemWrite;
  assign misaligned = (WordOrByte == WOB_WORD) && (ALUresult[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    word_d   = word_q;
    off_d    = off_q;
    ldata_d  = ldata_q;
    lvalid_d = 1'b0;
    err_d    = err_q;
    stall_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_c = 1'b1;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            // MemWrite wins when both strobes are set
            we_d    = MemWrite;
            addr_d  = {ALUresult[31:2], 2'b00};
            wdata_d = st_wdata;
            be_d    = st_be;
            word_d  = WordOrByte;
            off_d   = ALUresult[1:0];
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          req_d = 1'b0;
          if (!we_q) begin
            ldata_d  = ld_data;
            lvalid_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // inputs still show the completed instruction here, so they are ignored
      DONE: state_d = IDLE;
      ERR: begin
        stall_c = 1'b1;
        req_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      word_q   <= 1'b0;
      off_q    <= 2'd0;
      ldata_q  <= 32'd0;
      lvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      word_q   <= word_d;
      off_q    <= off_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
      err_q    <= err_d;
    end
  end

  assign stall      = stall_c & reset;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign load_data  = ldata_q;
  assign load_valid = lvalid_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected requests/loads are queued at
// stimulus time and compared when the DUT raises mem_req or load_valid.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        MemRead, MemWrite, WordOrByte;
  logic [31:0] ALUresult, rs2;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] load_data;
  logic        load_valid, mem_err;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .WordOrByte (WordOrByte),
    .ALUresult  (ALUresult),
    .rs2        (rs2),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .load_data  (load_data),
    .load_valid (load_valid),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] ld_q[$];
  req_t        cur;
  logic        req_prev = 1'b0;
  int          req_rises = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Monitor: compare each new request and each load result against the queues
  always @(negedge clk) begin
    if (mem_req && !req_prev) begin
      req_rises++;
      if (exp_q.size() == 0) begin
        check("unexpected_req", 32'(mem_req), 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("req_we", 32'(mem_we), 32'(cur.we));
        check("req_addr", mem_addr, cur.addr);
        check("req_be", 32'(mem_be), 32'(cur.be));
        check("req_wdata", mem_wdata, cur.wdata);
      end
    end
    req_prev = mem_req;
    if (load_valid) begin
      if (ld_q.size() == 0) check("unexpected_load_valid", 32'(load_valid), 32'd0);
      else check("load_data", load_data, ld_q.pop_front());
    end
  end

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; WordOrByte = 1'b0;
    ALUresult = 32'd0; rs2 = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_be"}, 32'(mem_be), 32'd0);
    check({tag, "_ldata"}, load_data, 32'd0);
    check({tag, "_lvalid"}, 32'(load_valid), 32'd0);
    check({tag, "_err"}, 32'(mem_err), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    idle_inputs();
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; ack_busy = which BUSY cycle (1-based) carries mem_ack.
  // Returns at the negedge that follows the DONE cycle, inputs still applied.
  task automatic do_access(input string tag, input logic mr, input logic mw, input logic wob,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_busy, input int exp_stall, input logic [3:0] e_be,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic [31:0] e_load);
    int stalls;
    bit done;
    req_t r;
    MemRead = mr; MemWrite = mw; WordOrByte = wob;
    ALUresult = addr; rs2 = wd; mem_rdata = rd; mem_ack = 1'b0;
    r.we = mw; r.addr = e_addr; r.be = e_be; r.wdata = e_wdata;
    exp_q.push_back(r);
    if (mr && !mw) ld_q.push_back(e_load);
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_ack = (ack_busy > 0) && (c == ack_busy);
      #1;
      if (stall) stalls++;
      else done = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
  endtask

  initial begin
    int cnt;
    int rises0;
    reset = 1'b1;
    idle_inputs();
    #2 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // word load, ack on 3rd BUSY cycle
    do_access("wload", 1, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4,
              4'b1111, 32'h100, 32'h0, 32'hDEADBEEF);
    idle_inputs();
    #1 check("wload_lvalid_one_cycle", 32'(load_valid), 32'd0);
    @(negedge clk);

    // byte loads with sign and zero extension
    do_access("bload103", 1, 0, 0, 32'h103, 32'h0, 32'h80112233, 1, 2,
              4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
    idle_inputs();
    @(negedge clk);
    do_access("bload101", 1, 0, 0, 32'h101, 32'h0, 32'h80112233, 2, 3,
              4'b0010, 32'h100, 32'h0, 32'h00000022);
    idle_inputs();
    @(negedge clk);

    // byte store followed back-to-back by another byte store
    rises0 = req_rises;
    do_access("bstore202", 0, 1, 0, 32'h202, 32'h000000A5, 32'h0, 1, 2,
              4'b0100, 32'h200, 32'hA5A5A5A5, 32'h0);
    do_access("bstore205", 0, 1, 0, 32'h205, 32'h1234563C, 32'h0, 1, 2,
              4'b0010, 32'h204, 32'h3C3C3C3C, 32'h0);
    idle_inputs();
    @(negedge clk);
    check("b2b_req_count", 32'(req_rises - rises0), 32'd2);

    // read+write together is a store
    do_access("rw_store", 1, 1, 1, 32'h104, 32'h12345678, 32'h0, 2, 3,
              4'b1111, 32'h104, 32'h12345678, 32'h0);
    idle_inputs();
    @(negedge clk);

    // reset asserted mid-BUSY
    MemRead = 1'b1; WordOrByte = 1'b1; ALUresult = 32'h400;
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h400; r.be = 4'b1111; r.wdata = 32'h0;
      exp_q.push_back(r);
    end
    @(negedge clk);
    @(negedge clk);
    check("midbusy_req_before", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("midbusy_req", 32'(mem_req), 32'd0);
    check("midbusy_stall", 32'(stall), 32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // timeout: no ack ever
    MemRead = 1'b1; WordOrByte = 1'b1; ALUresult = 32'h300;
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h300; r.be = 4'b1111; r.wdata = 32'h0;
      exp_q.push_back(r);
    end
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mem_req) cnt++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(cnt), 32'd4);
    check("timeout_err", 32'(mem_err), 32'd1);
    check("timeout_req_low", 32'(mem_req), 32'd0);
    #1 check("timeout_stall", 32'(stall), 32'd1);
    pulse_reset("to_rst");

    // misaligned word load
    MemRead = 1'b1; WordOrByte = 1'b1; ALUresult = 32'h102;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (mem_req) cnt++;
      @(negedge clk);
    end
    check("misal_req_cycles", 32'(cnt), 32'd0);
    check("misal_err", 32'(mem_err), 32'd1);
    #1 check("misal_stall", 32'(stall), 32'd1);
    pulse_reset("misal_rst");

    // normal operation after recovery
    do_access("post_rst_wload", 1, 0, 1, 32'h108, 32'h0, 32'hCAFEF00D, 1, 2,
              4'b1111, 32'h108, 32'h0, 32'hCAFEF00D);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);

    check("sb_req_left", 32'(exp_q.size()), 32'd0);
    check("sb_load_left", 32'(ld_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
